ppu_vsq_stream: RTL and testbench

- Parametrised successor of the PPU post-processing path for the systolic array.
- Accepts LANES partial sums per beat over a valid/ready stream, applies signed scale and bias, then ReLU and saturating truncation with optional rounding. Buffers one vector of BEATS beats and tracks the running max while writing.
- Computes the per-vector reciprocal with an iterative divider, then streams out saturated OUT_W-bit quantized beats with backpressure. Sits between the array accumulators and the softmax/writeback stage.

---
 rtl/ppu_vsq_stream.sv | 200 ++++++++++++++++++++
 tb/tb_ppu_vsq_stream.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_vsq_stream.sv
// Post-processing stream for the systolic array: scale/bias/ReLU/truncate into a
// one-vector buffer, restoring-divide the vector max, then drain quantized beats.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_FILL   | accepting input beats, writing buffer, tracking running max
// S_DIV    | restoring divider, one quotient bit per cycle, no input
// S_DRAIN  | presenting quantized beats downstream with backpressure
module ppu_vsq_stream #(
  parameter int LANES      = 16,
  parameter int PS_W       = 24,
  parameter int SCALE_W    = 8,
  parameter int BIAS_W     = 8,
  parameter int TRUNC_LSB  = 8,
  parameter int TRUNC_W    = 18,
  parameter int BEATS      = 16,
  parameter int OUT_W      = 8,
  parameter int RECIP_FRAC = 13,
  parameter int RECIP_W    = 18
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     round_en,
  input  logic [SCALE_W-1:0]       scale,
  input  logic [BIAS_W-1:0]        bias,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*PS_W-1:0]    in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*OUT_W-1:0]   out_data,
  output logic                     out_last,
  output logic [TRUNC_W-1:0]       out_max,
  output logic [RECIP_W-1:0]       out_recip,
  output logic                     busy
);

  localparam int PROD_W = PS_W + SCALE_W;
  localparam int SUM_W  = PROD_W + 2;
  localparam int NUM_W  = OUT_W + RECIP_FRAC;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int DIVC_W = $clog2(NUM_W);
  localparam int MUL_W  = TRUNC_W + RECIP_W;
  localparam int QEXT_W = NUM_W + RECIP_W;
  localparam logic [SUM_W-1:0] RND_C = {{(SUM_W-1){1'b0}}, 1'b1} << (TRUNC_LSB-1);
  localparam logic [NUM_W-1:0] NUMER = {{OUT_W{1'b1}}, {RECIP_FRAC{1'b0}}};

  typedef enum logic [1:0] {S_FILL, S_DIV, S_DRAIN} state_t;

  state_t                     r_state, w_state_nx;
  logic [CNT_W-1:0]           r_wr_cnt, r_rd_cnt;
  logic [DIVC_W-1:0]          r_div_cnt;
  logic [TRUNC_W-1:0]         r_max, w_bmax;
  logic [TRUNC_W-1:0]         r_rem, w_rem_nx;
  logic [NUM_W-1:0]           r_quo, w_quo_nx;
  logic [RECIP_W-1:0]         r_recip, w_recip;
  logic [LANES*TRUNC_W-1:0]   r_buf [BEATS];
  logic [LANES*TRUNC_W-1:0]   w_elem, w_rd_row;

  logic [SUM_W-1:0]  w_se, w_be, w_rc;
  logic [SUM_W-1:0]  w_xe  [LANES];
  logic [SUM_W-1:0]  w_sum [LANES];
  logic [SUM_W-1:0]  w_shr [LANES];
  logic [MUL_W-1:0]  w_mul [LANES];
  logic [MUL_W-1:0]  w_mq  [LANES];
  logic [TRUNC_W:0]  w_trial, w_diff;
  logic [QEXT_W-1:0] w_quo_ext;
  logic              w_ge, w_acc, w_hs, w_wr_last, w_rd_last, w_div_last;

  assign in_ready  = (r_state == S_FILL);
  assign out_valid = (r_state == S_DRAIN);
  assign busy      = (r_state != S_FILL);
  assign out_last  = out_valid & w_rd_last;
  assign out_max   = out_valid ? r_max : '0;
  assign out_recip = out_valid ? r_recip : '0;

  assign w_acc      = in_valid & in_ready & ~flush;
  assign w_hs       = out_valid & out_ready;
  assign w_wr_last  = (r_wr_cnt == CNT_W'(BEATS-1));
  assign w_rd_last  = (r_rd_cnt == CNT_W'(BEATS-1));
  assign w_div_last = (r_div_cnt == DIVC_W'(NUM_W-1));

  assign w_se = {{(SUM_W-SCALE_W){scale[SCALE_W-1]}}, scale};
  assign w_be = {{(SUM_W-BIAS_W){bias[BIAS_W-1]}}, bias};
  assign w_rc = round_en ? RND_C : '0;

  // Operands are sign-extended to SUM_W so the modular product equals the true product.
  always_comb begin
    w_elem = '0;
    for (int k = 0; k < LANES; k++) begin
      w_xe[k]  = {{(SUM_W-PS_W){in_data[k*PS_W+PS_W-1]}}, in_data[k*PS_W +: PS_W]};
      w_sum[k] = w_xe[k] * w_se + w_be;
      w_shr[k] = (w_sum[k] + w_rc) >> TRUNC_LSB;
      if (w_sum[k][SUM_W-1])
        w_elem[k*TRUNC_W +: TRUNC_W] = '0;
      else if (|w_shr[k][SUM_W-1:TRUNC_W])
        w_elem[k*TRUNC_W +: TRUNC_W] = '1;
      else
        w_elem[k*TRUNC_W +: TRUNC_W] = w_shr[k][TRUNC_W-1:0];
    end
  end

  always_comb begin
    w_bmax = r_max;
    for (int k = 0; k < LANES; k++)
      if (w_elem[k*TRUNC_W +: TRUNC_W] > w_bmax) w_bmax = w_elem[k*TRUNC_W +: TRUNC_W];
  end

  // Numerator shifts out of the quotient register MSB-first as quotient bits shift in.
  assign w_trial   = {r_rem, r_quo[NUM_W-1]};
  assign w_diff    = w_trial - {1'b0, r_max};
  assign w_ge      = (w_trial >= {1'b0, r_max});
  assign w_rem_nx  = w_ge ? w_diff[TRUNC_W-1:0] : w_trial[TRUNC_W-1:0];
  assign w_quo_nx  = {r_quo[NUM_W-2:0], w_ge};
  assign w_quo_ext = {{RECIP_W{1'b0}}, w_quo_nx};
  assign w_recip   = ((r_max == '0) || (|w_quo_ext[QEXT_W-1:RECIP_W])) ? '1
                                                                       : w_quo_ext[RECIP_W-1:0];

  assign w_rd_row = r_buf[r_rd_cnt];

  always_comb begin
    out_data = '0;
    for (int k = 0; k < LANES; k++) begin
      w_mul[k] = {{RECIP_W{1'b0}}, w_rd_row[k*TRUNC_W +: TRUNC_W]} * {{TRUNC_W{1'b0}}, r_recip};
      w_mq[k]  = w_mul[k] >> RECIP_FRAC;
      if (out_valid)
        out_data[k*OUT_W +: OUT_W] = (|w_mq[k][MUL_W-1:OUT_W]) ? '1 : w_mq[k][OUT_W-1:0];
    end
  end

  always_comb begin
    w_state_nx = r_state;
    if (flush) w_state_nx = S_FILL;
    else begin
      case (r_state)
        S_FILL:  if (w_acc && w_wr_last) w_state_nx = S_DIV;
        S_DIV:   if (w_div_last) w_state_nx = S_DRAIN;
        S_DRAIN: if (w_hs && w_rd_last) w_state_nx = S_FILL;
        default: w_state_nx = S_FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc) r_buf[r_wr_cnt] <= w_elem;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FILL;
      r_wr_cnt  <= '0;
      r_rd_cnt  <= '0;
      r_div_cnt <= '0;
      r_max     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_recip   <= '0;
    end else begin
      r_state <= w_state_nx;
      if (flush) begin
        r_wr_cnt  <= '0;
        r_rd_cnt  <= '0;
        r_div_cnt <= '0;
        r_max     <= '0;
      end else begin
        case (r_state)
          S_FILL: if (w_acc) begin
            r_max <= w_bmax;
            if (w_wr_last) begin
              r_wr_cnt  <= '0;
              r_rd_cnt  <= '0;
              r_div_cnt <= '0;
              r_rem     <= '0;
              r_quo     <= NUMER;
            end else begin
              r_wr_cnt <= r_wr_cnt + 1'b1;
            end
          end
          S_DIV: begin
            r_rem     <= w_rem_nx;
            r_quo     <= w_quo_nx;
            r_div_cnt <= r_div_cnt + 1'b1;
            if (w_div_last) r_recip <= w_recip;
          end
          S_DRAIN: if (w_hs) begin
            if (w_rd_last) begin
              r_rd_cnt <= '0;
              r_max    <= '0;
            end else begin
              r_rd_cnt <= r_rd_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ppu_vsq_stream.sv
// Directed bench for ppu_vsq_stream: broadcast-vector table plus hand-written
// sequences for latency, stalls, flush and reset.
module tb_ppu_vsq_stream;

  localparam int LANES = 16;
  localparam int PS_W  = 24;
  localparam int OUT_W = 8;
  localparam int BEATS = 16;

  logic                    clk, rst_n, flush, round_en;
  logic [7:0]              scale, bias;
  logic                    in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [LANES*PS_W-1:0]   in_data;
  logic [LANES*OUT_W-1:0]  out_data;
  logic [17:0]             out_max, out_recip;

  int n_checks = 0;
  int n_err    = 0;

  ppu_vsq_stream dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .round_en(round_en),
    .scale(scale), .bias(bias), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .out_max(out_max),
    .out_recip(out_recip), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          x;
    int          sc;
    int          bi;
    logic        rnd;
    logic [17:0] emax;
    logic [17:0] erecip;
    logic [7:0]  edata;
  } vec_t;

  vec_t tv [10];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_checks++;
    n_err++;
    $display("FAIL %s: got timeout expected handshake", nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LANES*PS_W-1:0] bcast(input int x);
    logic [LANES*PS_W-1:0] d;
    for (int k = 0; k < LANES; k++) d[k*PS_W +: PS_W] = x[PS_W-1:0];
    return d;
  endfunction

  function automatic logic [LANES*OUT_W-1:0] rep8(input logic [7:0] v);
    logic [LANES*OUT_W-1:0] d;
    for (int k = 0; k < LANES; k++) d[k*OUT_W +: OUT_W] = v;
    return d;
  endfunction

  // Nominal vector: scale 1, bias 0, no rounding, max 1000 so recip is 2088.
  function automatic logic [LANES*OUT_W-1:0] nom_exp(input logic [LANES*PS_W-1:0] d);
    logic [LANES*OUT_W-1:0] r;
    int unsigned e, o;
    for (int k = 0; k < LANES; k++) begin
      e = 32'(d[k*PS_W +: PS_W]) >> 8;
      o = (e * 2088) >> 13;
      if (o > 255) o = 255;
      r[k*OUT_W +: OUT_W] = o[7:0];
    end
    return r;
  endfunction

  task automatic send_beat(input logic [LANES*PS_W-1:0] d, input int sc, input int bi,
                           input logic rnd);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    scale    = sc[7:0];
    bias     = bi[7:0];
    round_en = rnd;
    n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) timeout("in_accept");
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_vec(input int x, input int sc, input int bi, input logic rnd,
                          input bit gaps);
    for (int b = 0; b < BEATS; b++) begin
      send_beat(bcast(x), sc, bi, rnd);
      if (gaps) repeat (b % 3) tick();
    end
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) timeout("out_valid_wait");
  endtask

  task automatic drain_bcast(input string nm, input logic [17:0] emax,
                             input logic [17:0] erecip, input logic [7:0] edata);
    int n;
    out_ready = 1'b1;
    for (int b = 0; b < BEATS; b++) begin
      wait_out(n);
      if (b == 0) begin
        chk({nm, "_max"}, out_max, emax);
        chk({nm, "_recip"}, out_recip, erecip);
      end
      chk({nm, "_data"}, out_data, rep8(edata));
      chk({nm, "_last"}, out_last, (b == BEATS-1));
      tick();
    end
    chk({nm, "_done_valid"}, out_valid, 1'b0);
    chk({nm, "_done_ready"}, in_ready, 1'b1);
  endtask

  initial begin
    logic [LANES*PS_W-1:0]  nb [BEATS];
    logic [LANES*OUT_W-1:0] held_data;
    logic                   held_last, bad;
    int                     n;

    tv[0] = '{x: -512,     sc: 1,    bi: 0,   rnd: 1'b0, emax: 0,      erecip: 262143, edata: 0};
    tv[1] = '{x: 384,      sc: 1,    bi: 0,   rnd: 1'b1, emax: 2,      erecip: 262143, edata: 63};
    tv[2] = '{x: 384,      sc: 1,    bi: 0,   rnd: 1'b0, emax: 1,      erecip: 262143, edata: 31};
    tv[3] = '{x: -1024,    sc: -1,   bi: 0,   rnd: 1'b0, emax: 4,      erecip: 262143, edata: 127};
    tv[4] = '{x: 0,        sc: 1,    bi: 0,   rnd: 1'b0, emax: 0,      erecip: 262143, edata: 0};
    tv[5] = '{x: 8388607,  sc: 127,  bi: 0,   rnd: 1'b0, emax: 262143, erecip: 7,      edata: 223};
    tv[6] = '{x: -8388608, sc: -128, bi: 0,   rnd: 1'b1, emax: 262143, erecip: 7,      edata: 223};
    tv[7] = '{x: 1000,     sc: 3,    bi: 100, rnd: 1'b0, emax: 12,     erecip: 174080, edata: 255};
    tv[8] = '{x: 0,        sc: 1,    bi: -1,  rnd: 1'b1, emax: 0,      erecip: 262143, edata: 0};
    tv[9] = '{x: 256000,   sc: 1,    bi: 0,   rnd: 1'b0, emax: 1000,   erecip: 2088,   edata: 254};

    rst_n = 1'b0; flush = 1'b0; round_en = 1'b0; scale = 8'd1; bias = 8'd0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #23;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_max", out_max, 18'd0);
    chk("rst_out_recip", out_recip, 18'd0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_last", out_last, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    // Nominal vector, latency, in_ready low while a beat is held through DIV/DRAIN.
    for (int b = 0; b < BEATS; b++) begin
      nb[b] = '0;
      for (int k = 0; k < LANES; k++) nb[b][k*PS_W +: PS_W] = 24'(k * 256);
    end
    nb[3][5*PS_W +: PS_W] = 24'd256000;
    for (int b = 0; b < BEATS; b++) send_beat(nb[b], 1, 0, 1'b0);
    in_valid = 1'b1;
    in_data  = bcast(2560);
    bad = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      if (in_ready || !busy) bad = 1'b1;
      tick();
      n++;
    end
    chk("nom_latency", 128'(n), 128'd21);
    chk("nom_div_in_ready_low", bad, 1'b0);
    chk("nom_max", out_max, 18'd1000);
    chk("nom_recip", out_recip, 18'd2088);
    out_ready = 1'b1;
    for (int b = 0; b < BEATS; b++) begin
      wait_out(n);
      chk("nom_data", out_data, nom_exp(nb[b]));
      chk("nom_last", out_last, (b == BEATS-1));
      chk("nom_drain_in_ready", in_ready, 1'b0);
      if (b == 0) begin
        chk("nom_lane0_zero", out_data[0 +: 8], 8'd0);
        chk("nom_lane15_e15", out_data[15*8 +: 8], 8'd3);
      end
      if (b == 3) chk("nom_e1000", out_data[5*8 +: 8], 8'd254);
      if (b == 2 || b == 9) begin
        out_ready = 1'b0;
        held_data = out_data;
        held_last = out_last;
        repeat (5) begin
          tick();
          chk("stall_valid", out_valid, 1'b1);
          chk("stall_data", out_data, held_data);
          chk("stall_last", out_last, held_last);
        end
        out_ready = 1'b1;
      end
      tick();
    end
    chk("nom_end_valid", out_valid, 1'b0);
    chk("nom_end_in_ready", in_ready, 1'b1);
    send_vec(2560, 1, 0, 1'b0, 1'b0);
    drain_bcast("held_vec", 18'd10, 18'd208896, 8'd255);

    for (int i = 0; i < 10; i++) begin
      send_vec(tv[i].x, tv[i].sc, tv[i].bi, tv[i].rnd, (i % 2) == 1);
      drain_bcast($sformatf("tv%0d", i), tv[i].emax, tv[i].erecip, tv[i].edata);
    end

    // Flush mid-FILL: partial large data must not leak into the next vector.
    for (int b = 0; b < 7; b++) send_beat(bcast(256000), 1, 0, 1'b0);
    flush = 1'b1;
    in_valid = 1'b1;
    in_data = bcast(256000);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_fill_busy", busy, 1'b0);
    send_vec(2560, 1, 0, 1'b0, 1'b0);
    drain_bcast("post_flush", 18'd10, 18'd208896, 8'd255);

    // Flush while beat 4 of the drain is presented.
    send_vec(2560, 1, 0, 1'b0, 1'b0);
    out_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      wait_out(n);
      tick();
    end
    out_ready = 1'b0;
    chk("flush_drain_pre_valid", out_valid, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_drain_valid", out_valid, 1'b0);
    chk("flush_drain_busy", busy, 1'b0);
    chk("flush_drain_in_ready", in_ready, 1'b1);
    chk("flush_drain_max", out_max, 18'd0);
    send_vec(25600, 1, 0, 1'b0, 1'b0);
    drain_bcast("post_flush2", 18'd100, 18'd20889, 8'd254);

    // Asynchronous reset in the middle of a drain.
    send_vec(2560, 1, 0, 1'b0, 1'b0);
    out_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      wait_out(n);
      tick();
    end
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", out_valid, 1'b0);
    chk("rst_mid_in_ready", in_ready, 1'b1);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_max", out_max, 18'd0);
    tick();
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (40) begin
      if (out_valid) bad = 1'b1;
      tick();
    end
    chk("rst_no_output", bad, 1'b0);
    send_vec(384, 1, 0, 1'b1, 1'b1);
    drain_bcast("post_rst", 18'd2, 18'd262143, 8'd63);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
